// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states, default cycle counts.
// Latency: n/a (constants and pure combinational helpers only).
// Backpressure: n/a.
package mdu_pkg;

  // md_op encodings
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Default busy lengths
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [2:0] op);
    return is_mult(op) || is_div(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU (signed ops via magnitude + sign fixup).
// Latency: 0 cycles, purely combinational; the controller decides when results are consumed.
// Backpressure: none; outputs are only meaningful for mult/div opcodes (zero otherwise).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [63:0] w_prod;

  // One unsigned datapath serves both signednesses: operate on magnitudes, then restore signs.
  // Magnitude of 0x8000_0000 is 2^31 as an unsigned value, so the most negative operand needs no special case.
  always_comb begin
    w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
    w_neg_a  = w_signed & i_rs[31];
    w_neg_b  = w_signed & i_rt[31];
    w_mag_a  = w_neg_a ? -i_rs : i_rs;
    w_mag_b  = w_neg_b ? -i_rt : i_rt;
    w_prod   = {32'd0, w_mag_a} * {32'd0, w_mag_b};
    w_q_mag  = 32'd0;
    w_r_mag  = 32'd0;
    if (w_mag_b != 32'd0) begin
      w_q_mag = w_mag_a / w_mag_b;
      w_r_mag = w_mag_a % w_mag_b;
    end
    o_hi = 32'd0;
    o_lo = 32'd0;
    if (is_div(i_md_op)) begin
      if (i_rt == 32'd0) begin
        // Defined divide-by-zero result: remainder is the dividend, quotient all ones.
        o_hi = i_rs;
        o_lo = 32'hFFFF_FFFF;
      end else begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        o_lo = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
        o_hi = w_neg_a ? -w_r_mag : w_r_mag;
      end
    end else if (is_mult(i_md_op)) begin
      {o_hi, o_lo} = (w_neg_a ^ w_neg_b) ? -w_prod : w_prod;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, holds results in pending regs and commits after a fixed busy window.
// Latency: MULT_CYC cycles (mult) / DIV_CYC cycles (div) after the issue edge; MTHI/MTLO update at the issue edge.
// Backpressure: combinational stall to the pipeline; issues during RUN are dropped. Macro MDU_DIV0_GUARD_EN rejects divide-by-zero.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_p_hi;
  logic [31:0] r_p_lo;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_accept;
  logic [3:0]  w_load_cnt;

  mdu_arith u_arith (
    .i_md_op (md_op),
    .i_rs    (rs_val),
    .i_rt    (rt_val),
    .o_hi    (w_res_hi),
    .o_lo    (w_res_lo)
  );

`ifdef MDU_DIV0_GUARD_EN
  // A zero divisor is rejected outright: the op never enters RUN and HI/LO keep their values.
  assign w_accept = is_muldiv(md_op) && !(is_div(md_op) && (rt_val == 32'd0));
`else
  // A zero divisor runs the full divide window and commits the defined div-by-zero result.
  assign w_accept = is_muldiv(md_op);
`endif

  assign w_load_cnt = is_div(md_op) ? 4'(DIV_CYC) : 4'(MULT_CYC);

  assign busy  = (r_state == ST_RUN);
  assign stall = d_is_md & (busy | (start & is_muldiv(md_op)));
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Issue, count down and commit; HI/LO only move at MTHI/MTLO issue or at commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_p_hi  <= 32'd0;
      r_p_lo  <= 32'd0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        if (w_accept) begin
          r_p_hi  <= w_res_hi;
          r_p_lo  <= w_res_lo;
          r_cnt   <= w_load_cnt;
          r_state <= ST_RUN;
        end else if (md_op == MD_MTHI) begin
          r_hi <= rs_val;
        end else if (md_op == MD_MTLO) begin
          r_lo <= rs_val;
        end
      end
    end else begin
      // Any start seen here is ignored; <= 1 also recovers if the count were ever zero in RUN.
      if (r_cnt <= 4'd1) begin
        r_hi    <= r_p_hi;
        r_lo    <= r_p_lo;
        r_cnt   <= 4'd0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for single ops plus hand sequences for stall, reset abort and back-to-back issue.
// Latency: checks busy length against the default MULT_CYC=5 / DIV_CYC=10.
// Backpressure: drives d_is_md and checks the combinational stall output. Honours MDU_DIV0_GUARD_EN.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          e_cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at the current point (just after a rising edge), then count busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int ncyc, output bit stable);
    logic [31:0] h0;
    logic [31:0] l0;
    start  = 1'b1;
    md_op  = op;
    rs_val = rs;
    rt_val = rt;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = MD_NONE;
    h0 = hi;
    l0 = lo;
    ncyc   = 0;
    stable = 1'b1;
    while (busy === 1'b1 && ncyc < 40) begin
      ncyc++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int  n;
    bit  st;
    int  stall_bad;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    md_op = MD_NONE;
    rs_val = 32'd0;
    rt_val = 32'd0;
    d_is_md = 1'b1;

    vecs[0]  = '{"mult_neg",   MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{"multu_max",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{"divu_100_7", MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[3]  = '{"div_m7_2",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{"div_7_m2",   MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[5]  = '{"mult_min2",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[6]  = '{"mthi",       MD_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h0000_0000, 0};
    vecs[7]  = '{"mtlo",       MD_MTLO,  32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
    vecs[8]  = '{"none",       MD_NONE,  32'h0000_9999, 32'd1,         32'h0000_1234, 32'h0000_5678, 0};
    vecs[9]  = '{"reserved",   MD_RSVD,  32'h0000_9999, 32'd1,         32'h0000_1234, 32'h0000_5678, 0};
`ifdef MDU_DIV0_GUARD_EN
    vecs[10] = '{"div_by0",    MD_DIV,   32'h0000_0042, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
`else
    vecs[10] = '{"div_by0",    MD_DIV,   32'h0000_0042, 32'd0,         32'h0000_0042, 32'hFFFF_FFFF, 10};
`endif
    vecs[11] = '{"div_min_m1", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[12] = '{"divu_max_1", MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 10};

    // Reset state, with d_is_md high and start low
    #12;
    check32("rst_busy",  {31'd0, busy},  32'd0);
    check32("rst_stall", {31'd0, stall}, 32'd0);
    check32("rst_hi",    hi,             32'd0);
    check32("rst_lo",    lo,             32'd0);
    d_is_md = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table: each op issued immediately after the previous one finishes
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, n, st);
      check32({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].e_cyc));
      check32({vecs[i].name, "_hi"}, hi, vecs[i].e_hi);
      check32({vecs[i].name, "_lo"}, lo, vecs[i].e_lo);
      check32({vecs[i].name, "_stable"}, {31'd0, st}, 32'd1);
    end

    // NONE issue with d_is_md: no stall while idle
    d_is_md = 1'b1;
    start = 1'b1;
    md_op = MD_NONE;
    #1;
    check32("stall_none_idle", {31'd0, stall}, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;

    // MULTU 3x4 with d_is_md held, MTLO 0x55 dropped mid-RUN
    start = 1'b1;
    md_op = MD_MULTU;
    rs_val = 32'd3;
    rt_val = 32'd4;
    #1;
    check32("stall_issue", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = MD_NONE;
    n = 0;
    stall_bad = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (stall !== 1'b1) stall_bad++;
      if (n == 2) begin
        start = 1'b1;
        md_op = MD_MTLO;
        rs_val = 32'h55;
      end else begin
        start = 1'b0;
        md_op = MD_NONE;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    md_op = MD_NONE;
    check32("stall_busy_cycles", 32'(n), 32'd5);
    check32("stall_during_busy_bad", 32'(stall_bad), 32'd0);
    check32("stall_after", {31'd0, stall}, 32'd0);
    check32("mtlo_ignored_lo", lo, 32'd12);
    check32("mtlo_ignored_hi", hi, 32'd0);

    // Reset in busy cycle 3 of a DIV aborts with no later commit
    run_op_start_only: begin
      start = 1'b1;
      md_op = MD_DIV;
      rs_val = 32'd100;
      rt_val = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = MD_NONE;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
    check32("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check32("abort_busy", {31'd0, busy},  32'd0);
    check32("abort_hi",   hi,             32'd0);
    check32("abort_lo",   lo,             32'd0);
    check32("abort_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d_is_md = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check32("post_abort_busy", {31'd0, busy}, 32'd0);
    check32("post_abort_hi",   hi,            32'd0);
    check32("post_abort_lo",   lo,            32'd0);

    // Back-to-back: MULT commit, MTHI next cycle, then a MULTU right after
    run_op(MD_MULT, 32'd2, 32'd3, n, st);
    check32("b2b_mult_cycles", 32'(n), 32'd5);
    check32("b2b_mult_lo", lo, 32'd6);
    start = 1'b1;
    md_op = MD_MTHI;
    rs_val = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = MD_NONE;
    check32("b2b_mthi_hi",   hi,             32'h0000_ABCD);
    check32("b2b_mthi_lo",   lo,             32'd6);
    check32("b2b_mthi_busy", {31'd0, busy},  32'd0);
    run_op(MD_MULTU, 32'd5, 32'd5, n, st);
    check32("b2b_multu_cycles", 32'(n), 32'd5);
    check32("b2b_multu_hi", hi, 32'd0);
    check32("b2b_multu_lo", lo, 32'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5: cycles busy for MULT/MULTU (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYC, default 10: cycles busy for DIV/DIVU (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage issue pulse for md_op.
REQ-006 SHALL have port md_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 SHALL have port rs_val  input  32  first operand (dividend / MTHI/MTLO source).
REQ-008 SHALL have port rt_val  input  32  second operand (divisor).
REQ-009 SHALL have port d_is_md  input  1  D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port stall  output  1  freeze request to the pipeline.
REQ-012 SHALL have port hi  output  32  architectural HI.
REQ-013 SHALL have port lo  output  32  architectural LO.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-015 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL capture the result into pending regs (p_hi, p_lo), load cnt with MULT_CYC or DIV_CYC, and go to RUN at that edge.
REQ-016 Signed ops SHALL use two's-complement operands; unsigned ops zero-extended; MULT: {hi,lo}=64-bit product; DIV: lo=quotient truncated toward zero, hi=remainder with dividend's sign.
REQ-017 busy SHALL be 1 for exactly N cycles after the start edge (N = loaded count); at the edge ending the Nth cycle hi/lo SHALL take p_hi/p_lo, busy SHALL drop, FSM SHALL return to IDLE.
REQ-018 MTHI/MTLO with start in IDLE SHALL write rs_val to hi/lo at that edge; busy stays 0.
REQ-019 Any start while in RUN (including MTHI/MTLO) SHALL be ignored: no change to cnt, pending regs, hi, or lo.
REQ-020 start with NONE/reserved SHALL cause no state change.
REQ-021 stall SHALL be combinational: d_is_md & (busy | (start & md_op in {1,2,3,4})).
REQ-022 A new start in the cycle immediately after busy falls SHALL be accepted normally (no dead cycle).
REQ-023 hi/lo SHALL stay stable throughout RUN; the previous values remain readable until commit.

Reset
REQ-024 Reset SHALL force IDLE, cnt=0, busy=0, hi=0, lo=0, p_hi=0, p_lo=0 immediately, regardless of clk.
REQ-025 Reset during RUN SHALL abort the operation; no commit SHALL occur after reset deasserts.
REQ-026 stall SHALL be 0 during reset when start=0.

Configuration
REQ-027 Macro MDU_DIV0_GUARD_EN SHALL select divide-by-zero handling.
REQ-028 With MDU_DIV0_GUARD_EN defined: DIV/DIVU with rt_val=0 SHALL not enter RUN; hi/lo unchanged, busy stays 0.
REQ-029 Without it: divide-by-zero SHALL run DIV_CYC cycles and commit hi=rs_val, lo=32'hFFFF_FFFF.

Structure
REQ-030 Package mdu_pkg SHALL hold the md_op encodings, FSM state encoding, and default cycle constants.
REQ-031 One sub-module, mdu_arith (combinational 64-bit mult/div result generation), SHALL be used; mdu_ctrl owns all sequencing.

Verification
REQ-032 MULT rs=0xFFFF_FFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
REQ-033 DIVU rs=100, rt=7 -> busy high 10 cycles, then lo=14, hi=2; DIV rs=-7, rt=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
REQ-034 MULTU 3x4 with d_is_md=1 throughout -> stall=1 in start cycle and all 5 busy cycles, 0 after; MTLO 0x55 issued mid-RUN -> ignored, lo=12 at commit.
REQ-035 DIV rt=0 -> with guard: busy never rises, hi/lo unchanged; without: 10 busy cycles then hi=rs_val, lo=0xFFFF_FFFF.
REQ-036 Reset asserted at busy cycle 3 of a DIV -> busy, hi, lo = 0 immediately; no commit after release.
REQ-037 Back-to-back: MULT committed, next cycle MTHI 0xABCD -> hi=0xABCD one edge later, busy=0.
